// File: rtl/wb_write_queue.sv
// Writeback collector that merges ALU and multdiv results into an in-order FIFO and
// retires one register-file write per cycle. Define WB_FORWARD_EN to build the forwarding mux.
module wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic               clock,
  input  logic               ctrl_reset,
  input  logic               alu_valid,
  input  logic [4:0]         alu_reg,
  input  logic [31:0]        alu_data,
  output logic               alu_ready,
  input  logic               mdv_valid,
  input  logic [4:0]         mdv_reg,
  input  logic [31:0]        mdv_data,
  output logic               mdv_ready,
  output logic               ctrl_writeEnable,
  output logic [4:0]         ctrl_writeReg,
  output logic [31:0]        data_writeReg,
  input  logic [4:0]         ctrl_readRegA,
  input  logic [4:0]         ctrl_readRegB,
  output logic               hazard_A,
  output logic               hazard_B,
  output logic [31:0]        fwd_dataA,
  output logic [31:0]        fwd_dataB,
  output logic [PTR_W:0]     occupancy
);

  logic [PTR_W:0]   count;
  logic [PTR_W:0]   countNext;
  logic [PTR_W:0]   freeSlots;
  logic [PTR_W-1:0] headPtr;
  logic [PTR_W-1:0] tailPtr;
  logic [PTR_W-1:0] aluSlot;
  logic [DEPTH-1:0] entryValid;
  logic [4:0]       regMem  [DEPTH];
  logic [31:0]      dataMem [DEPTH];

  logic mdvPush;
  logic aluPush;
  logic doPop;

  // Space comes from the registered count only; a same-cycle pop never frees a slot.
  assign freeSlots = (PTR_W+1)'(DEPTH) - count;
  assign mdv_ready = (freeSlots != '0);
  assign alu_ready = (freeSlots >= (PTR_W+1)'(2)) ||
                     ((freeSlots == (PTR_W+1)'(1)) && !mdv_valid);

  // Writes to r0 complete the handshake but are discarded.
  assign mdvPush = mdv_valid && mdv_ready && (mdv_reg != 5'd0);
  assign aluPush = alu_valid && alu_ready && (alu_reg != 5'd0);
  assign doPop   = (count != '0);

  // Multdiv takes the tail slot first when both producers land together.
  assign aluSlot   = tailPtr + {{(PTR_W-1){1'b0}}, mdvPush};
  assign countNext = count + {{PTR_W{1'b0}}, mdvPush} + {{PTR_W{1'b0}}, aluPush}
                           - {{PTR_W{1'b0}}, doPop};
  assign occupancy = count;

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      count            <= '0;
      headPtr          <= '0;
      tailPtr          <= '0;
      entryValid       <= '0;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= 5'd0;
      data_writeReg    <= 32'd0;
    end else begin
      ctrl_writeEnable <= doPop;
      if (doPop) begin
        ctrl_writeReg       <= regMem[headPtr];
        data_writeReg       <= dataMem[headPtr];
        entryValid[headPtr] <= 1'b0;
        headPtr             <= headPtr + 1'b1;
      end
      if (mdvPush) entryValid[tailPtr] <= 1'b1;
      if (aluPush) entryValid[aluSlot] <= 1'b1;
      tailPtr <= aluSlot + {{(PTR_W-1){1'b0}}, aluPush};
      count   <= countNext;
    end
  end

  // Storage needs no reset; validity is tracked by entryValid.
  always_ff @(posedge clock) begin
    if (!ctrl_reset) begin
      if (mdvPush) begin
        regMem[tailPtr]  <= mdv_reg;
        dataMem[tailPtr] <= mdv_data;
      end
      if (aluPush) begin
        regMem[aluSlot]  <= alu_reg;
        dataMem[aluSlot] <= alu_data;
      end
    end
  end

  always_comb begin
    hazard_A = ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegA);
    hazard_B = ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegB);
    for (int i = 0; i < DEPTH; i++) begin
      if (entryValid[i] && (regMem[i] == ctrl_readRegA)) hazard_A = 1'b1;
      if (entryValid[i] && (regMem[i] == ctrl_readRegB)) hazard_B = 1'b1;
    end
    if (ctrl_readRegA == 5'd0) hazard_A = 1'b0;
    if (ctrl_readRegB == 5'd0) hazard_B = 1'b0;
  end

`ifdef WB_FORWARD_EN
  logic [PTR_W-1:0] scanIdx;

  // Walk head to tail so the youngest match overwrites older ones.
  always_comb begin
    scanIdx   = '0;
    fwd_dataA = 32'd0;
    fwd_dataB = 32'd0;
    if (ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegA)) fwd_dataA = data_writeReg;
    if (ctrl_writeEnable && (ctrl_writeReg == ctrl_readRegB)) fwd_dataB = data_writeReg;
    for (int i = 0; i < DEPTH; i++) begin
      scanIdx = headPtr + PTR_W'(i);
      if (entryValid[scanIdx] && (regMem[scanIdx] == ctrl_readRegA)) fwd_dataA = dataMem[scanIdx];
      if (entryValid[scanIdx] && (regMem[scanIdx] == ctrl_readRegB)) fwd_dataB = dataMem[scanIdx];
    end
    if (!hazard_A) fwd_dataA = 32'd0;
    if (!hazard_B) fwd_dataB = 32'd0;
  end
`else
  assign fwd_dataA = 32'd0;
  assign fwd_dataB = 32'd0;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Randomized self-checking bench for wb_write_queue against a queue-based reference model.
module tb_wb_write_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic         clock = 1'b0;
  logic         ctrl_reset;
  logic         alu_valid, mdv_valid;
  logic [4:0]   alu_reg, mdv_reg;
  logic [31:0]  alu_data, mdv_data;
  logic         alu_ready, mdv_ready;
  logic         ctrl_writeEnable;
  logic [4:0]   ctrl_writeReg;
  logic [31:0]  data_writeReg;
  logic [4:0]   ctrl_readRegA, ctrl_readRegB;
  logic         hazard_A, hazard_B;
  logic [31:0]  fwd_dataA, fwd_dataB;
  logic [PTR_W:0] occupancy;

  wb_write_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clock            (clock),
    .ctrl_reset       (ctrl_reset),
    .alu_valid        (alu_valid),
    .alu_reg          (alu_reg),
    .alu_data         (alu_data),
    .alu_ready        (alu_ready),
    .mdv_valid        (mdv_valid),
    .mdv_reg          (mdv_reg),
    .mdv_data         (mdv_data),
    .mdv_ready        (mdv_ready),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .hazard_A         (hazard_A),
    .hazard_B         (hazard_B),
    .fwd_dataA        (fwd_dataA),
    .fwd_dataB        (fwd_dataB),
    .occupancy        (occupancy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic        oWe;
  logic [4:0]  oReg;
  logic [31:0] oData;
  int          nVec = 0;
  int          nErr = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic expHaz(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (oWe && oReg == a) return 1'b1;
    foreach (q[i]) if (q[i].r == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] expFwd(input logic [4:0] a);
`ifdef WB_FORWARD_EN
    if (a == 5'd0) return 32'd0;
    for (int i = q.size() - 1; i >= 0; i--) if (q[i].r == a) return q[i].d;
    if (oWe && oReg == a) return oData;
`endif
    return 32'd0;
  endfunction

  // Drive one cycle of inputs, check at the falling edge, advance the model at the rising edge.
  task automatic step(input logic rst, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic mv, input logic [4:0] mr, input logic [31:0] md,
                      input logic [4:0] ra, input logic [4:0] rb);
    int   freeN;
    logic eMdvRdy, eAluRdy;
    ctrl_reset = rst;
    alu_valid = av; alu_reg = ar; alu_data = ad;
    mdv_valid = mv; mdv_reg = mr; mdv_data = md;
    ctrl_readRegA = ra; ctrl_readRegB = rb;
    @(negedge clock);
    freeN   = DEPTH - q.size();
    eMdvRdy = (freeN >= 1);
    eAluRdy = (freeN >= 2) || (freeN == 1 && !mv);
    checkVal("mdv_ready", mdv_ready, eMdvRdy);
    checkVal("alu_ready", alu_ready, eAluRdy);
    checkVal("occupancy", occupancy, q.size());
    checkVal("writeEnable", ctrl_writeEnable, oWe);
    checkVal("writeReg", ctrl_writeReg, oReg);
    checkVal("writeData", data_writeReg, oData);
    checkVal("hazard_A", hazard_A, expHaz(ra));
    checkVal("hazard_B", hazard_B, expHaz(rb));
    checkVal("fwd_dataA", fwd_dataA, expFwd(ra));
    checkVal("fwd_dataB", fwd_dataB, expFwd(rb));
    if (rst) begin
      q.delete();
      oWe = 1'b0; oReg = 5'd0; oData = 32'd0;
    end else begin
      if (q.size() > 0) begin
        oWe = 1'b1; oReg = q[0].r; oData = q[0].d;
        void'(q.pop_front());
      end else begin
        oWe = 1'b0;
      end
      if (mv && eMdvRdy && mr != 5'd0) q.push_back('{r: mr, d: md});
      if (av && eAluRdy && ar != 5'd0) q.push_back('{r: ar, d: ad});
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n, input logic [4:0] ra);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, ra, 5'd0);
  endtask

  initial begin
    ctrl_reset = 1'b1;
    alu_valid = 1'b0; alu_reg = 5'd0; alu_data = 32'd0;
    mdv_valid = 1'b0; mdv_reg = 5'd0; mdv_data = 32'd0;
    ctrl_readRegA = 5'd0; ctrl_readRegB = 5'd0;
    oWe = 1'b0; oReg = 5'd0; oData = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    ctrl_reset = 1'b0;

    // Single ALU write and its latency.
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    checkVal("t1_we", ctrl_writeEnable, 32'd1);
    checkVal("t1_reg", ctrl_writeReg, 32'd5);
    checkVal("t1_data", data_writeReg, 32'hDEADBEEF);
    idle(2, 5'd5);

    // Both producers held valid: multdiv wins the last slot.
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 5'(10 + k % 4), 32'h2000 + k, 1'b1, 5'(20 + k % 4), 32'h1000 + k,
           5'd10, 5'd20);
      if (k == 1) begin
        checkVal("full_occ", occupancy, 32'd3);
        checkVal("full_alu_rdy", alu_ready, 32'd0);
        checkVal("full_mdv_rdy", mdv_ready, 32'd1);
      end
    end
    idle(6, 5'd10);

    // Write to r0 is accepted and dropped.
    step(1'b0, 1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    checkVal("r0_occ", occupancy, 32'd0);
    idle(2, 5'd0);

    // Duplicate destinations retire in order.
    step(1'b0, 1'b1, 5'd7, 32'h11, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7);
    step(1'b0, 1'b1, 5'd7, 32'h22, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7);
    idle(3, 5'd7);

    // Reset mid-flight discards queued entries.
    for (int k = 0; k < 2; k++)
      step(1'b0, 1'b1, 5'(3 + k), 32'hA0 + k, 1'b1, 5'(8 + k), 32'hB0 + k, 5'd3, 5'd8);
    step(1'b1, 1'b1, 5'd9, 32'hC0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd8);
    checkVal("rst_occ", occupancy, 32'd0);
    checkVal("rst_we", ctrl_writeEnable, 32'd0);
    idle(3, 5'd3);

    // Continuous single ALU stream wraps the pointers.
    for (int k = 0; k < 10; k++)
      step(1'b0, 1'b1, 5'd12, 32'h500 + k, 1'b0, 5'd0, 32'd0, 5'd12, 5'd0);
    checkVal("stream_occ", occupancy, 32'd1);
    idle(3, 5'd12);

    // Random traffic.
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 49) == 0),
           ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
